// File: rtl/decrypt_loop3_if.sv
// Memory-side bus of the RC4 decrypt stage: S RAM, encrypted ROM and decrypted RAM.
interface decrypt_loop3_if #(
  parameter int unsigned MSG_AW = 5
);
  logic [7:0]        s_address;
  logic [7:0]        s_data;
  logic              s_wren;
  logic [7:0]        s_q;
  logic [MSG_AW-1:0] enc_address;
  logic [7:0]        enc_q;
  logic [MSG_AW-1:0] dec_address;
  logic [7:0]        dec_data;
  logic              dec_wren;

  modport master (
    output s_address, s_data, s_wren, enc_address, dec_address, dec_data, dec_wren,
    input  s_q, enc_q
  );

  modport slave (
    input  s_address, s_data, s_wren, enc_address, dec_address, dec_data, dec_wren,
    output s_q, enc_q
  );
endinterface

// File: rtl/decrypt_loop3.sv
// RC4 keystream generation and decrypt: walks the encrypted ROM, swaps S entries,
// writes plaintext to the decrypted RAM and flags any illegal plaintext byte.
module decrypt_loop3 #(
  parameter int unsigned MSG_LEN     = 32,
  parameter int unsigned MSG_AW      = 5,
  parameter bit          CHECK_CHARS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  decrypt_loop3_if.master  mem,
  output logic             finish,
  output logic             key_valid
);

  localparam int unsigned SW = 8;

  typedef enum logic [3:0] {
    IDLE, RD_I, LD_I, RD_J, LD_J, WR_I, WR_J, RD_F, LD_F, WR_D, DONE
  } state_t;

  state_t            state, state_d;
  logic [SW-1:0]     i, i_d, j, j_d, si, si_d, sj, sj_d, f, f_d, e, e_d;
  logic [MSG_AW-1:0] k, k_d;
  logic              key_valid_d, finish_d;

  logic [SW-1:0]     s_address_r, s_address_d, s_data_r, s_data_d;
  logic              s_wren_r, s_wren_d;
  logic [MSG_AW-1:0] enc_address_r, enc_address_d, dec_address_r, dec_address_d;
  logic [SW-1:0]     dec_data_r, dec_data_d;
  logic              dec_wren_r, dec_wren_d;

  logic [SW-1:0]     plain;
  logic              legal;

  assign plain = f ^ e;
  assign legal = (plain == 8'h20) || ((plain >= 8'h61) && (plain <= 8'h7A));

  assign mem.s_address   = s_address_r;
  assign mem.s_data      = s_data_r;
  assign mem.s_wren      = s_wren_r;
  assign mem.enc_address = enc_address_r;
  assign mem.dec_address = dec_address_r;
  assign mem.dec_data    = dec_data_r;
  assign mem.dec_wren    = dec_wren_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      i             <= '0;
      j             <= '0;
      k             <= '0;
      si            <= '0;
      sj            <= '0;
      f             <= '0;
      e             <= '0;
      key_valid     <= 1'b0;
      finish        <= 1'b0;
      s_address_r   <= '0;
      s_data_r      <= '0;
      s_wren_r      <= 1'b0;
      enc_address_r <= '0;
      dec_address_r <= '0;
      dec_data_r    <= '0;
      dec_wren_r    <= 1'b0;
    end else begin
      state         <= state_d;
      i             <= i_d;
      j             <= j_d;
      k             <= k_d;
      si            <= si_d;
      sj            <= sj_d;
      f             <= f_d;
      e             <= e_d;
      key_valid     <= key_valid_d;
      finish        <= finish_d;
      s_address_r   <= s_address_d;
      s_data_r      <= s_data_d;
      s_wren_r      <= s_wren_d;
      enc_address_r <= enc_address_d;
      dec_address_r <= dec_address_d;
      dec_data_r    <= dec_data_d;
      dec_wren_r    <= dec_wren_d;
    end
  end

  // Next state and datapath; outputs are derived from the next state so that
  // the registered bus shows each state's address during that state.
  always_comb begin
    state_d       = state;
    i_d           = i;
    j_d           = j;
    k_d           = k;
    si_d          = si;
    sj_d          = sj;
    f_d           = f;
    e_d           = e;
    key_valid_d   = key_valid;
    finish_d      = 1'b0;
    s_address_d   = '0;
    s_data_d      = '0;
    s_wren_d      = 1'b0;
    enc_address_d = '0;
    dec_address_d = '0;
    dec_data_d    = '0;
    dec_wren_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          i_d         = SW'(1);
          j_d         = '0;
          k_d         = '0;
          key_valid_d = 1'b1;
          state_d     = RD_I;
        end
      end
      RD_I: state_d = LD_I;
      LD_I: begin
        si_d    = mem.s_q;
        j_d     = j + mem.s_q;
        state_d = RD_J;
      end
      RD_J: state_d = LD_J;
      LD_J: begin
        sj_d    = mem.s_q;
        state_d = WR_I;
      end
      WR_I: state_d = WR_J;
      WR_J: state_d = RD_F;
      RD_F: state_d = LD_F;
      LD_F: begin
        f_d     = mem.s_q;
        e_d     = mem.enc_q;
        state_d = WR_D;
      end
      WR_D: begin
        if (CHECK_CHARS && !legal) begin
          key_valid_d = 1'b0;
          state_d     = DONE;
        end else if (k == MSG_AW'(MSG_LEN - 1)) begin
          state_d = DONE;
        end else begin
          k_d     = k + MSG_AW'(1);
          i_d     = i + SW'(1);
          state_d = RD_I;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      RD_I: s_address_d = i_d;
      RD_J: s_address_d = j_d;
      WR_I: begin
        s_address_d = i_d;
        s_data_d    = sj_d;
        s_wren_d    = 1'b1;
      end
      WR_J: begin
        s_address_d = j_d;
        s_data_d    = si_d;
        s_wren_d    = 1'b1;
      end
      // pre-swap si+sj equals the post-swap sum
      RD_F: begin
        s_address_d   = si_d + sj_d;
        enc_address_d = k_d;
      end
      WR_D: begin
        dec_address_d = k_d;
        dec_data_d    = f_d ^ e_d;
        dec_wren_d    = 1'b1;
      end
      DONE:    finish_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decrypt_loop3.sv
// Scoreboard bench for decrypt_loop3: two instances (character check on/off)
// share stimulus and are compared against a plain RC4 reference model.
module tb_decrypt_loop3;

  localparam int MSG_LEN = 32;
  localparam int MSG_AW  = 5;

  typedef logic [7:0] sbox_t [256];
  typedef logic [7:0] msg_t  [MSG_LEN];
  typedef struct packed {
    logic [MSG_AW-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic clk = 1'b0;
  logic reset, start, load;
  logic finish0, key_valid0, finish1, key_valid1;
  int   cyc = 0;

  logic [7:0]        s_init  [256];
  logic [7:0]        enc_mem [MSG_LEN];
  logic [7:0]        s_mem0  [256];
  logic [7:0]        s_mem1  [256];
  logic [7:0]        s_ar0, s_ar1;
  logic [MSG_AW-1:0] e_ar0, e_ar1;

  wr_t        exp_q [2][$];
  int         fin_q [2][$];
  int         fin_cnt [2];
  int         fin_tgt [2];
  logic [7:0] cap [2][MSG_LEN];
  int         checks = 0;
  int         failures = 0;

  decrypt_loop3_if #(.MSG_AW(MSG_AW)) bus0 ();
  decrypt_loop3_if #(.MSG_AW(MSG_AW)) bus1 ();

  decrypt_loop3 #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW), .CHECK_CHARS(1'b1)) dut0 (
    .clk(clk), .reset(reset), .start(start), .mem(bus0.master),
    .finish(finish0), .key_valid(key_valid0)
  );

  decrypt_loop3 #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW), .CHECK_CHARS(1'b0)) dut1 (
    .clk(clk), .reset(reset), .start(start), .mem(bus1.master),
    .finish(finish1), .key_valid(key_valid1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories with registered address, as in the FPGA RAM/ROM blocks
  always @(posedge clk) begin
    s_ar0 <= bus0.s_address;
    e_ar0 <= bus0.enc_address;
    if (load) for (int n = 0; n < 256; n++) s_mem0[n] <= s_init[n];
    else if (bus0.s_wren) s_mem0[bus0.s_address] <= bus0.s_data;
  end
  assign bus0.s_q   = s_mem0[s_ar0];
  assign bus0.enc_q = enc_mem[e_ar0];

  always @(posedge clk) begin
    s_ar1 <= bus1.s_address;
    e_ar1 <= bus1.enc_address;
    if (load) for (int n = 0; n < 256; n++) s_mem1[n] <= s_init[n];
    else if (bus1.s_wren) s_mem1[bus1.s_address] <= bus1.s_data;
  end
  assign bus1.s_q   = s_mem1[s_ar1];
  assign bus1.enc_q = enc_mem[e_ar1];

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit legal(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  // Textbook RC4 PRGA over the whole message, stopping at an illegal byte when checking
  task automatic model_prga(input bit check, input sbox_t s_in, input msg_t enc,
                            output sbox_t s_out, output msg_t dec, output int n, output bit kv);
    sbox_t s;
    logic [7:0] i, j, t, tmp;
    s = s_in; i = 8'd0; j = 8'd0; kv = 1'b1; n = 0;
    for (int k = 0; k < MSG_LEN; k++) dec[k] = 8'h00;
    for (int k = 0; k < MSG_LEN; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      t = s[i] + s[j];
      dec[k] = enc[k] ^ s[t];
      n = k + 1;
      if (check && !legal(dec[k])) begin
        kv = 1'b0;
        break;
      end
    end
    s_out = s;
  endtask

  task automatic ksa(input logic [23:0] key, output sbox_t s);
    logic [7:0] j, tmp, kb;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      kb = (n % 3 == 0) ? key[23:16] : (n % 3 == 1) ? key[15:8] : key[7:0];
      j = j + s[n] + kb;
      tmp = s[n]; s[n] = s[j]; s[j] = tmp;
    end
  endtask

  task automatic identity(output sbox_t s);
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
  endtask

  // Ciphertext whose plaintext is legal except (optionally) at bad_pos
  task automatic make_enc(input sbox_t s, input int bad_pos, output msg_t enc);
    msg_t zero, ks;
    sbox_t so;
    int n, r;
    bit kv;
    logic [7:0] pt;
    for (int k = 0; k < MSG_LEN; k++) zero[k] = 8'h00;
    model_prga(1'b0, s, zero, so, ks, n, kv);
    for (int k = 0; k < MSG_LEN; k++) begin
      r  = $urandom_range(0, 26);
      pt = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      if (k == bad_pos) pt = 8'h80 | 8'($urandom_range(0, 127));
      enc[k] = pt ^ ks[k];
    end
  endtask

  task automatic expect_one(input int inst, input sbox_t s, input msg_t enc, input int s0,
                            output sbox_t so, output bit kv, output int n);
    msg_t d;
    wr_t w;
    model_prga(inst == 0, s, enc, so, d, n, kv);
    for (int k = 0; k < n; k++) begin
      w.addr = MSG_AW'(k);
      w.data = d[k];
      exp_q[inst].push_back(w);
    end
    fin_q[inst].push_back(s0 + 9 * n);
    fin_tgt[inst]++;
  endtask

  task automatic mon(input int inst, input logic wren, input logic [MSG_AW-1:0] addr,
                     input logic [7:0] data, input logic fin);
    wr_t w;
    int  e;
    if (wren) begin
      if (exp_q[inst].size() == 0) chk(1'b0, $sformatf("unexpected_dec_wren%0d", inst), int'(addr), -1);
      else begin
        w = exp_q[inst].pop_front();
        chk(addr == w.addr, $sformatf("dec_address%0d", inst), int'(addr), int'(w.addr));
        chk(data == w.data, $sformatf("dec_data%0d[%0d]", inst, w.addr), int'(data), int'(w.data));
      end
      cap[inst][addr] = data;
    end
    if (fin) begin
      fin_cnt[inst]++;
      if (fin_q[inst].size() == 0) chk(1'b0, $sformatf("unexpected_finish%0d", inst), cyc, -1);
      else begin
        e = fin_q[inst].pop_front();
        chk(cyc == e, $sformatf("finish_cycle%0d", inst), cyc, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      mon(0, bus0.dec_wren, bus0.dec_address, bus0.dec_data, finish0);
      mon(1, bus1.dec_wren, bus1.dec_address, bus1.dec_data, finish1);
    end
  end

  task automatic load_mem(input sbox_t s, input msg_t enc);
    @(negedge clk);
    for (int n = 0; n < 256; n++) s_init[n] = s[n];
    for (int k = 0; k < MSG_LEN; k++) enc_mem[k] = enc[k];
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({bus0.s_address, bus0.s_data, bus0.s_wren, bus0.enc_address, bus0.dec_address,
         bus0.dec_data, bus0.dec_wren, finish0, key_valid0} == '0, {tag, "_zero0"}, 1, 0);
    chk({bus1.s_address, bus1.s_data, bus1.s_wren, bus1.enc_address, bus1.dec_address,
         bus1.dec_data, bus1.dec_wren, finish1, key_valid1} == '0, {tag, "_zero1"}, 1, 0);
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (c < 2000 && !(fin_cnt[0] >= fin_tgt[0] && fin_cnt[1] >= fin_tgt[1])) begin
      @(negedge clk);
      c++;
    end
    chk(fin_cnt[0] >= fin_tgt[0], "finish_timeout0", fin_cnt[0], fin_tgt[0]);
    chk(fin_cnt[1] >= fin_tgt[1], "finish_timeout1", fin_cnt[1], fin_tgt[1]);
    repeat (4) @(negedge clk);
  endtask

  task automatic post_check(input sbox_t so0, input sbox_t so1, input bit kv0, input bit kv1);
    int bad0, bad1;
    bad0 = 0; bad1 = 0;
    for (int n = 0; n < 256; n++) begin
      if (s_mem0[n] !== so0[n]) bad0++;
      if (s_mem1[n] !== so1[n]) bad1++;
    end
    chk(bad0 == 0, "s_final0", bad0, 0);
    chk(bad1 == 0, "s_final1", bad1, 0);
    chk(key_valid0 === kv0, "key_valid0", int'(key_valid0), int'(kv0));
    chk(key_valid1 === kv1, "key_valid1", int'(key_valid1), int'(kv1));
    chk(fin_cnt[0] == fin_tgt[0], "finish_count0", fin_cnt[0], fin_tgt[0]);
    chk(fin_cnt[1] == fin_tgt[1], "finish_count1", fin_cnt[1], fin_tgt[1]);
    chk(exp_q[0].size() == 0, "pending_writes0", exp_q[0].size(), 0);
    chk(exp_q[1].size() == 0, "pending_writes1", exp_q[1].size(), 0);
  endtask

  // One run; optionally toggles start randomly while both instances are busy
  task automatic do_run(input sbox_t s, input msg_t enc, input bit wiggle);
    sbox_t so0, so1;
    bit kv0, kv1;
    int n0, n1, s0, nmin;
    load_mem(s, enc);
    s0 = cyc + 1;
    expect_one(0, s, enc, s0, so0, kv0, n0);
    expect_one(1, s, enc, s0, so1, kv1, n1);
    nmin = (n0 < n1) ? n0 : n1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (wiggle)
      for (int c = 1; c < 9 * nmin - 1; c++) begin
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    start = 1'b0;
    wait_done();
    post_check(so0, so1, kv0, kv1);
  endtask

  initial begin
    sbox_t s, so0, so1, sa0, sa1;
    msg_t  enc;
    bit    kv0, kv1;
    int    n0, n1, s0, s0b;

    reset = 1'b1; start = 1'b0; load = 1'b0;
    fin_cnt = '{0, 0}; fin_tgt = '{0, 0};
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) reset = 1'b0;

    // Identity S: keystream 2 then 5
    identity(s);
    for (int k = 0; k < MSG_LEN; k++) enc[k] = 8'($urandom);
    enc[0] = 8'h63; enc[1] = 8'h62;
    do_run(s, enc, 1'b0);
    chk(cap[0][0] == 8'h61, "ident_dec0", int'(cap[0][0]), 8'h61);
    chk(cap[0][1] == 8'h67, "ident_dec1", int'(cap[0][1]), 8'h67);

    // Golden key, legal plaintext
    ksa(24'h000249, s);
    make_enc(s, -1, enc);
    do_run(s, enc, 1'b0);

    // Illegal first byte: checking instance aborts, the other runs to the end
    identity(s);
    for (int k = 0; k < MSG_LEN; k++) enc[k] = 8'h00;
    do_run(s, enc, 1'b0);
    chk(cap[0][0] == 8'h02, "illegal_dec0", int'(cap[0][0]), 8'h02);
    chk(key_valid0 === 1'b0, "illegal_kv0", int'(key_valid0), 0);
    chk(key_valid1 === 1'b1, "nocheck_kv1", int'(key_valid1), 1);

    // Reset during WR_I of byte 5, then a fresh run
    ksa(24'($urandom), s);
    make_enc(s, -1, enc);
    load_mem(s, enc);
    s0 = cyc + 1;
    expect_one(0, s, enc, s0, so0, kv0, n0);
    expect_one(1, s, enc, s0, so1, kv1, n1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    chk(bus0.s_wren === 1'b1 && bus0.s_address == 8'd6, "wr_i_byte5", int'(bus0.s_address), 6);
    reset = 1'b1;
    @(posedge clk);
    #1 check_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    for (int q = 0; q < 2; q++) begin
      exp_q[q].delete();
      fin_q[q].delete();
      fin_tgt[q] = fin_cnt[q];
    end
    repeat (3) @(negedge clk);
    check_zero("idle_after_reset");
    do_run(s, enc, 1'b0);

    // Start held high: a second run follows the IDLE cycle after finish
    ksa(24'($urandom), s);
    make_enc(s, -1, enc);
    load_mem(s, enc);
    s0  = cyc + 1;
    expect_one(0, s, enc, s0, sa0, kv0, n0);
    expect_one(1, s, enc, s0, sa1, kv1, n1);
    s0b = s0 + 9 * MSG_LEN + 2;
    expect_one(0, sa0, enc, s0b, so0, kv0, n0);
    expect_one(1, sa1, enc, s0b, so1, kv1, n1);
    start = 1'b1;
    repeat (9 * MSG_LEN + 3) @(negedge clk);
    start = 1'b0;
    wait_done();
    post_check(so0, so1, kv0, kv1);

    // Random keys, occasionally an illegal byte, start toggling mid-run
    for (int r = 0; r < 8; r++) begin
      ksa(24'($urandom), s);
      make_enc(s, $urandom_range(0, 2 * MSG_LEN - 1), enc);
      do_run(s, enc, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decrypt_loop3.md
Name: decrypt_loop3

Overview:
RC4 pseudo-random generation and decrypt stage. It runs after the key-scheduling shuffle has finished permuting the 256-byte S memory. It walks the encrypted message ROM, generates one keystream byte per message byte (swapping S entries as it goes), and writes the XOR result into the decrypted-message RAM. It also flags whether every decrypted byte is a legal plaintext character, so the key-search controller can reject the key early.

Parameters:
MSG_LEN, 32, number of message bytes to decrypt (1..2^MSG_AW).
MSG_AW, 5, address width of the encrypted ROM and the decrypted RAM.
CHECK_CHARS, 1, when 1 an illegal plaintext byte clears key_valid and aborts; when 0 no checking is done.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin decryption; sampled only in IDLE
s_q  in  8  S RAM read data
s_address  out  8  S RAM address
s_data  out  8  S RAM write data
s_wren  out  1  S RAM write enable
enc_address  out  MSG_AW  encrypted ROM address
enc_q  in  8  encrypted ROM data
dec_address  out  MSG_AW  decrypted RAM address
dec_data  out  8  decrypted RAM write data
dec_wren  out  1  decrypted RAM write enable
finish  out  1  one-cycle done pulse
key_valid  out  1  1 = all bytes written so far were legal

Behaviour:
- Memories: the address is registered inside the RAM/ROM. Data for the address driven in state X is valid on q during state X+1 and is captured at the end of X+1.
- Reset, including mid-operation: state <= IDLE; i, j, k, si, sj, f, e <= 0; key_valid <= 0. All outputs are 0 on the next cycle; no partial write completes afterwards.
- Arithmetic: i, j and all S addresses are 8-bit and wrap mod 256. k counts 0..MSG_LEN-1.
- States, one cycle each except IDLE:
  - IDLE: all wren = 0, finish = 0. When start = 1: i <= 1, j <= 0, k <= 0, key_valid <= 1, go to RD_I.
  - RD_I: s_address = i.
  - LD_I: si <= s_q; j <= j + s_q.
  - RD_J: s_address = j (updated j).
  - LD_J: sj <= s_q.
  - WR_I: s_address = i, s_data = sj, s_wren = 1.
  - WR_J: s_address = j, s_data = si, s_wren = 1.
  - RD_F: s_address = si + sj; enc_address = k.
  - LD_F: f <= s_q; e <= enc_q.
  - WR_D: dec_address = k, dec_data = f ^ e, dec_wren = 1.
    - Legal bytes are 0x61..0x7A and 0x20.
    - If CHECK_CHARS = 1 and the byte is illegal: key_valid <= 0, go to DONE. The illegal byte is still written.
    - Else if k == MSG_LEN-1: go to DONE.
    - Else: k <= k+1, i <= i+1, go to RD_I.
  - DONE: finish = 1 for exactly one cycle, go to IDLE. key_valid holds until the next start or reset.
- Case i == j: WR_I and WR_J write the same address with the same value. This is legal and needs no special handling.
- The keystream address uses the registered pre-swap si and sj. Their sum equals the post-swap sum.
- Timing: 9 cycles per byte. For a full run, finish is high on cycle 9*MSG_LEN+1 after the start-sampling edge.
- If start is still high in IDLE after DONE, a new run starts. The controller drops start on finish.
- s_address, s_data, enc_address and dec_address are don't-care while their enable is 0, but must be 0 after reset.

Test Plan:
1. Identity S (S[n] = n), enc[0] = 0x63, enc[1] = 0x62 -> dec[0] = 0x61 with keystream 2 (i = j = 1, self-swap). dec[1] = 0x67 with keystream 5 (i = 2, j = 3). Afterwards S[2] = 3 and S[3] = 2.
2. S loaded from the golden KSA of key 0x000249, enc loaded with the matching ciphertext, MSG_LEN = 32 -> all 32 dec bytes match the software model. key_valid = 1. finish pulses exactly once, 289 cycles after start. S contents match the model's final permutation.
3. CHECK_CHARS = 1, identity S, enc[0] = 0x00 -> dec[0] = 0x02 written. key_valid = 0. finish 10 cycles after start. No further dec_wren.
4. Same stimulus with CHECK_CHARS = 0 -> all 32 bytes written. key_valid stays 1. finish at cycle 289.
5. Assert reset during WR_I of byte 5 -> next cycle s_wren = dec_wren = finish = key_valid = 0, state IDLE. A following start restarts at i = 1, j = 0, k = 0 and matches the model from a freshly reloaded S.
6. Hold start high continuously -> a second run begins the cycle after the finish pulse. No start is accepted while busy (pulse start mid-run: no effect on k, i or j).
